// File: rtl/dds_pkg.sv
// Shared types for the polyphonic DDS: FSM states, note-table entry, output sizing.
// Optional per-voice volume is enabled with `define DDS_VOLUME_EN.
package dds_pkg;

  // Table fields are stored at these widths and zero-extended from the write port.
  localparam int unsigned INC_W_MAX = 32;
  localparam int unsigned AMP_W_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                 en;
    logic [INC_W_MAX-1:0] inc;
`ifdef DDS_VOLUME_EN
    logic [AMP_W_MAX-1:0] vol;
`endif
  } note_t;

  // Frame-sum width: VOICES full-scale contributions can never overflow it.
  function automatic int unsigned sum_width(input int unsigned voices, input int unsigned amp_w);
`ifdef DDS_VOLUME_EN
    return $clog2(voices) + amp_w;
`else
    // Single-bit contribution per voice.
    return $clog2(voices) + ((amp_w < 1) ? amp_w : 1);
`endif
  endfunction

endpackage

// File: rtl/dds_voice_step.sv
// One voice update: next phase accumulator and its contribution to the frame sum.
// Contribution width is set by the parent (volume or a single gate bit, see DDS_VOLUME_EN).
module dds_voice_step #(
  parameter int unsigned ACC_W = 26,
  parameter int unsigned INC_W = 32,
  parameter int unsigned CON_W = 8
) (
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  input  logic [CON_W-1:0] vol,
  input  logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] acc_new,
  output logic [CON_W-1:0] contribution
);

  localparam int unsigned EXT_W = (ACC_W > INC_W) ? ACC_W : INC_W;

  // Gated-off voices are parked at phase 0 so the next note-on starts cleanly.
  always_comb begin
    acc_new      = en ? ACC_W'(EXT_W'(acc) + EXT_W'(inc)) : '0;
    contribution = (en && acc_new[ACC_W-1]) ? vol : '0;
  end

endmodule

// File: rtl/dds_poly_synth.sv
// Time-multiplexed polyphonic square-wave DDS: one voice updated per clock, frame sum per sample.
// `define DDS_VOLUME_EN to store and apply a per-voice volume; otherwise each voice adds one bit.
module dds_poly_synth
  import dds_pkg::*;
#(
  parameter int unsigned VOICES     = 64,
  parameter int unsigned ACC_W      = 26,
  parameter int unsigned INC_W      = 24,
  parameter int unsigned AMP_W      = 4,
  parameter int unsigned SAMPLE_DIV = 1536,
  localparam int unsigned VA_W      = $clog2(VOICES),
  localparam int unsigned SUM_W     = sum_width(VOICES, AMP_W)
) (
  input  logic             i_clk,
  input  logic             i_res_n,
  input  logic [VA_W-1:0]  i_note_addr,
  input  logic             i_note_en,
  input  logic [INC_W-1:0] i_add_val,
  input  logic [AMP_W-1:0] i_note_vol,
  input  logic             i_note_wren,
  output logic [SUM_W-1:0] o_sound,
  output logic             o_sample_vld
);

  localparam int unsigned FC_W = $clog2(SAMPLE_DIV);
`ifdef DDS_VOLUME_EN
  localparam int unsigned CON_W = AMP_W_MAX;
`else
  localparam int unsigned CON_W = 1;
`endif
  localparam int unsigned ADD_W = (SUM_W > CON_W) ? SUM_W : CON_W;

  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  state_t           state_q, state_d;
  note_t            tbl_q [VOICES];
  logic [ACC_W-1:0] acc_q [VOICES];
  logic [SUM_W-1:0] sum_q, sum_d, base_c, sound_d;
  logic             vld_d, scan_c;
  logic [VA_W-1:0]  idx_c;
  note_t            cur_c, wr_note;
  logic [CON_W-1:0] vol_c, con_c;
  logic [ACC_W-1:0] acc_cur_c, acc_new_c;

  // Write-port payload, widened to the stored entry format.
  always_comb begin
    wr_note     = '0;
    wr_note.en  = i_note_en;
    wr_note.inc = INC_W_MAX'(i_add_val);
`ifdef DDS_VOLUME_EN
    wr_note.vol = AMP_W_MAX'(i_note_vol);
`endif
  end

`ifndef DDS_VOLUME_EN
  logic unused_vol;
  assign unused_vol = ^i_note_vol;
`endif

  // The scanned voice index is simply the frame cycle number.
  assign idx_c     = VA_W'(fcnt_q);
  assign cur_c     = tbl_q[idx_c];
  assign acc_cur_c = acc_q[idx_c];
`ifdef DDS_VOLUME_EN
  assign vol_c = cur_c.vol;
`else
  assign vol_c = 1'b1;
`endif

  dds_voice_step #(
    .ACC_W (ACC_W),
    .INC_W (INC_W_MAX),
    .CON_W (CON_W)
  ) u_step (
    .en           (cur_c.en),
    .inc          (cur_c.inc),
    .vol          (vol_c),
    .acc          (acc_cur_c),
    .acc_new      (acc_new_c),
    .contribution (con_c)
  );

  always_comb begin
    base_c = (idx_c == '0) ? '0 : sum_q;
    sum_d  = SUM_W'(ADD_W'(base_c) + ADD_W'(con_c));
    fcnt_d = (fcnt_q == FC_W'(SAMPLE_DIV - 1)) ? '0 : fcnt_q + FC_W'(1);
  end

  // Frame FSM: scan steps happen on cycles 0..VOICES-1; DONE presents the sum.
  always_comb begin
    state_d = state_q;
    scan_c  = 1'b0;
    sound_d = o_sound;
    vld_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fcnt_q == '0) begin
          scan_c  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan_c = 1'b1;
        if (fcnt_q == FC_W'(VOICES - 1)) begin
          state_d = ST_DONE;
          sound_d = sum_d;
          vld_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      fcnt_q       <= '0;
      state_q      <= ST_IDLE;
      sum_q        <= '0;
      o_sound      <= '0;
      o_sample_vld <= 1'b0;
    end else begin
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      o_sound      <= sound_d;
      o_sample_vld <= vld_d;
      if (scan_c) sum_q <= sum_d;
    end
  end

  // Scan reads the old entry combinationally, so a same-edge write lands next frame.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      for (int v = 0; v < int'(VOICES); v++) begin
        tbl_q[v] <= '0;
        acc_q[v] <= '0;
      end
    end else begin
      if (i_note_wren) tbl_q[i_note_addr] <= wr_note;
      if (scan_c) acc_q[idx_c] <= acc_new_c;
    end
  end

endmodule

// File: tb/tb_dds_poly_synth.sv
// Scoreboard bench for dds_poly_synth (small config); honours DDS_VOLUME_EN like the RTL.
module tb_dds_poly_synth;

  localparam int unsigned VOICES     = 4;
  localparam int unsigned ACC_W      = 8;
  localparam int unsigned INC_W      = 8;
  localparam int unsigned AMP_W      = 4;
  localparam int unsigned SAMPLE_DIV = 8;
`ifdef DDS_VOLUME_EN
  localparam int unsigned SUM_W = 6;
`else
  localparam int unsigned SUM_W = 3;
`endif

  logic             clk = 1'b0;
  logic             res_n = 1'b0;
  logic [1:0]       note_addr = '0;
  logic             note_en = 1'b0;
  logic [INC_W-1:0] add_val = '0;
  logic [AMP_W-1:0] note_vol = '0;
  logic             note_wren = 1'b0;
  logic [SUM_W-1:0] sound;
  logic             sample_vld;

  always #5 clk = ~clk;

  dds_poly_synth #(
    .VOICES     (VOICES),
    .ACC_W      (ACC_W),
    .INC_W      (INC_W),
    .AMP_W      (AMP_W),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) dut (
    .i_clk        (clk),
    .i_res_n      (res_n),
    .i_note_addr  (note_addr),
    .i_note_en    (note_en),
    .i_add_val    (add_val),
    .i_note_vol   (note_vol),
    .i_note_wren  (note_wren),
    .o_sound      (sound),
    .o_sample_vld (sample_vld)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int m_en[VOICES], m_inc[VOICES], m_vol[VOICES], m_acc[VOICES];
  int m_sum, m_fcnt, last_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < int'(VOICES); v++) begin
      m_en[v] = 0; m_inc[v] = 0; m_vol[v] = 0; m_acc[v] = 0;
    end
    m_sum = 0; m_fcnt = 0; last_exp = 0;
    exp_q.delete();
  endtask

  // Behaviour of one rising edge whose frame cycle is m_fcnt.
  task automatic model_edge(input bit wren, input int addr, input bit en, input int inc, input int vol);
    int c;
    if (m_fcnt < int'(VOICES)) begin
      if (m_en[m_fcnt] != 0) m_acc[m_fcnt] = (m_acc[m_fcnt] + m_inc[m_fcnt]) % (1 << ACC_W);
      else m_acc[m_fcnt] = 0;
      c = 0;
      if (m_en[m_fcnt] != 0 && m_acc[m_fcnt] >= (1 << (ACC_W - 1))) begin
`ifdef DDS_VOLUME_EN
        c = m_vol[m_fcnt];
`else
        c = 1;
`endif
      end
      m_sum = ((m_fcnt == 0) ? 0 : m_sum) + c;
      if (m_fcnt == int'(VOICES) - 1) exp_q.push_back(m_sum);
    end
    if (wren) begin
      m_en[addr] = int'(en); m_inc[addr] = inc; m_vol[addr] = vol;
    end
    m_fcnt = (m_fcnt + 1) % int'(SAMPLE_DIV);
  endtask

  // Called at a falling edge: drive, clock once, check at the next falling edge.
  task automatic step(input bit wren, input int addr, input bit en, input int inc, input int vol);
    bit exp_vld;
    note_wren = wren; note_addr = 2'(addr); note_en = en;
    add_val = INC_W'(inc); note_vol = AMP_W'(vol);
    model_edge(wren, addr, en, inc, vol);
    @(negedge clk);
    note_wren = 1'b0;
    exp_vld = (m_fcnt == int'(VOICES));
    check("sample_vld", 32'(sample_vld), 32'(exp_vld));
    if (exp_vld) begin
      if (exp_q.size() == 0) check("scoreboard_empty_at_pulse", 32'(exp_q.size()), 32'd1);
      else begin
        last_exp = exp_q.pop_front();
        check("sound", 32'(sound), 32'(last_exp));
      end
    end else begin
      check("sound_hold", 32'(sound), 32'(last_exp));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic goto_cycle(input int f);
    for (int i = 0; i < int'(SAMPLE_DIV) && m_fcnt != f; i++) step(1'b0, 0, 1'b0, 0, 0);
    check("reach_frame_cycle", 32'(m_fcnt), 32'(f));
  endtask

  task automatic write_all(input bit en, input int inc, input int vol);
    for (int v = 0; v < int'(VOICES); v++) step(1'b1, v, en, inc, vol);
  endtask

  task automatic release_reset();
    @(negedge clk);
    res_n = 1'b1;
    model_clear();
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_sound", 32'(sound), 32'd0);
    check("reset_vld", 32'(sample_vld), 32'd0);
    release_reset();

    // Idle: pulses at cycles 4, 12, 20 with a zero sum.
    idle(3 * SAMPLE_DIV);

    // Voice 0 alone, half-rate square.
    goto_cycle(6);
    step(1'b1, 0, 1'b1, 128, 15);
    idle(4 * SAMPLE_DIV);

    // Park every voice, then start all in phase.
    goto_cycle(5);
    write_all(1'b0, 0, 0);
    idle(SAMPLE_DIV);
    goto_cycle(5);
    write_all(1'b1, 128, 15);
    idle(3 * SAMPLE_DIV);

    // Note-off for voice 2 on the very cycle voice 2 is scanned.
    goto_cycle(2);
    step(1'b1, 2, 1'b0, 0, 0);
    idle(3 * SAMPLE_DIV);

    // Volume-only and increment variety, including writes during the scan.
    goto_cycle(0);
    step(1'b1, 1, 1'b1, 64, 9);
    step(1'b1, 2, 1'b1, 200, 3);
    step(1'b1, 3, 1'b1, 255, 7);
    idle(4 * SAMPLE_DIV);
    for (int i = 0; i < 12 * int'(SAMPLE_DIV); i++) begin
      if ($urandom_range(0, 2) == 0)
        step(1'b1, int'($urandom_range(0, VOICES - 1)), 1'(($urandom_range(0, 3) != 0)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
      else
        step(1'b0, 0, 1'b0, 0, 0);
    end

    // Reset in the middle of a scan with voices sounding.
    goto_cycle(5);
    write_all(1'b1, 128, 15);
    idle(2 * SAMPLE_DIV);
    goto_cycle(2);
    res_n = 1'b0;
    #1;
    check("midscan_reset_sound", 32'(sound), 32'd0);
    check("midscan_reset_vld", 32'(sample_vld), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("reset_held_vld", 32'(sample_vld), 32'd0);
    end
    release_reset();
    idle(3 * SAMPLE_DIV);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
